// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fwd_pkg;

    // Operand source encodings driven on each fwd_sel slice
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Widest register address the shadow entries can hold; narrower
    // addresses are zero-extended, which keeps equality exact.
    localparam int FWD_MAX_AW = 16;

    // One shadow pipeline entry
    typedef struct packed {
        logic [FWD_MAX_AW-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } stage_t;

    // Ceiling log2 usable in constant expressions; fwd_clog2(1) = 0
    function automatic int fwd_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Destination/source match: hit when the entry really writes a register equal to src.
// Latency: combinational.
// Backpressure: none.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0] rd,
    input  logic          regwrite,
    input  logic [AW-1:0] src,
    output logic          hit
);

    logic writes;

    // Writes to r0 are discarded when r0 is hard-wired, so they never match
    assign writes = regwrite && (!ZERO_REG || (rd != '0));
    assign hit    = writes && (rd == src);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, write-through bypass and load-use stall for the EX stage.
// Latency: all outputs combinational from id_* inputs and shadow state updated each clk.
// Backpressure: stall holds PC/IF-ID for LOAD_LAT cycles after a load-use; bubble = stall | flush.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 flush,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic [NSRC-1:0]      id_bypass,
    output logic                 stall,
    output logic                 bubble
);

    localparam int            CW       = fwd_clog2(LOAD_LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LAT - 1);

    if (NSRC != 2 && NSRC != 3) begin : g_bad_nsrc
        $error("fwd_hazard_unit: NSRC must be 2 or 3");
    end
    if (LOAD_LAT < 1 || LOAD_LAT > 4) begin : g_bad_lat
        $error("fwd_hazard_unit: LOAD_LAT must be 1..4");
    end
    if (AW < 1 || AW > FWD_MAX_AW) begin : g_bad_aw
        $error("fwd_hazard_unit: AW out of range");
    end

    stage_t                idex;
    stage_t                exmem;
    stage_t                memwb;
    logic [NSRC*AW-1:0]    idex_src;
    logic [CW-1:0]         cnt;

    logic [NSRC-1:0]       hit_exmem;
    logic [NSRC-1:0]       hit_memwb;
    logic [NSRC-1:0]       hit_load;
    logic                  detect;
    logic                  kill;

    // A load in MEM/WB has already produced its data, so only the ID/EX
    // copy of memread matters; the later copies just travel along.
    logic                  unused_memwb_memread;
    assign unused_memwb_memread = memwb.memread;

    // ID/EX takes a bubble on stall, flush or an empty ID slot
    assign kill = stall | flush | !id_valid;

    // Shadow pipeline: ID/EX captures ID (or a bubble), later stages always advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex     <= '0;
            idex_src <= '0;
            exmem    <= '0;
            memwb    <= '0;
        end else begin
            if (kill) begin
                idex     <= '0;
                idex_src <= '0;
            end else begin
                idex.rd       <= FWD_MAX_AW'(id_rd);
                idex.regwrite <= id_regwrite;
                idex.memread  <= id_memread;
                idex_src      <= id_src;
            end
            exmem <= idex;
            memwb <= exmem;
        end
    end

    // Per-operand comparators: EX operands against EX/MEM and MEM/WB,
    // ID operands against MEM/WB (write-through) and ID/EX (load-use).
    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [FWD_MAX_AW-1:0] ex_src;
        logic [FWD_MAX_AW-1:0] dec_src;
        logic [1:0]            sel;

        assign ex_src  = FWD_MAX_AW'(idex_src[k*AW +: AW]);
        assign dec_src = FWD_MAX_AW'(id_src[k*AW +: AW]);

        fwd_match #(.AW(FWD_MAX_AW), .ZERO_REG(ZERO_REG)) u_exmem (
            .rd       (exmem.rd),
            .regwrite (exmem.regwrite),
            .src      (ex_src),
            .hit      (hit_exmem[k])
        );

        fwd_match #(.AW(FWD_MAX_AW), .ZERO_REG(ZERO_REG)) u_memwb (
            .rd       (memwb.rd),
            .regwrite (memwb.regwrite),
            .src      (ex_src),
            .hit      (hit_memwb[k])
        );

        fwd_match #(.AW(FWD_MAX_AW), .ZERO_REG(ZERO_REG)) u_bypass (
            .rd       (memwb.rd),
            .regwrite (memwb.regwrite),
            .src      (dec_src),
            .hit      (id_bypass[k])
        );

        fwd_match #(.AW(FWD_MAX_AW), .ZERO_REG(ZERO_REG)) u_load (
            .rd       (idex.rd),
            .regwrite (idex.regwrite),
            .src      (dec_src),
            .hit      (hit_load[k])
        );

        // Youngest producer wins: EX/MEM before MEM/WB, so never both bits
        always_comb begin
            sel = FWD_RF;
            if (hit_exmem[k]) begin
                sel = FWD_EXMEM;
            end else if (hit_memwb[k]) begin
                sel = FWD_MEMWB;
            end
        end

        assign fwd_sel[k*2 +: 2] = sel;
    end

    assign detect = id_valid && idex.memread && (|hit_load);

    // Stall counter: arms on a fresh detect, counts down, flush cancels it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end else if (detect) begin
            cnt <= CNT_LOAD;
        end
    end

    assign stall  = detect | (cnt != '0);
    assign bubble = stall | flush;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench for fwd_hazard_unit: three variants share one stimulus stream.
// Latency: expectations are queued per cycle and checked at the falling edge.
// Backpressure: the stimulus holds the consumer in ID while a variant stalls.
module tb_fwd_hazard_unit;

    localparam int AW   = 5;
    localparam int NSRC = 2;

    // Variant indices and observed fields
    localparam int W_A  = 0;   // LOAD_LAT=1, ZERO_REG=1
    localparam int W_L3 = 1;   // LOAD_LAT=3, ZERO_REG=1
    localparam int W_Z0 = 2;   // LOAD_LAT=1, ZERO_REG=0
    localparam int F_FWD = 0;
    localparam int F_STL = 1;
    localparam int F_BUB = 2;
    localparam int F_BYP = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic [NSRC*AW-1:0]  id_src;
    logic [AW-1:0]       id_rd;
    logic                id_regwrite;
    logic                id_memread;
    logic                flush;

    logic [NSRC*2-1:0]   fwd_sel   [3];
    logic [NSRC-1:0]     id_bypass [3];
    logic                stall     [3];
    logic                bubble    [3];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    int           q_cyc[$];
    int           q_which[$];
    int           q_fld[$];
    logic [7:0]   q_val[$];
    string        q_tag[$];

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(1), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .fwd_sel(fwd_sel[0]), .id_bypass(id_bypass[0]), .stall(stall[0]), .bubble(bubble[0])
    );

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(3), .ZERO_REG(1'b1)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .fwd_sel(fwd_sel[1]), .id_bypass(id_bypass[1]), .stall(stall[1]), .bubble(bubble[1])
    );

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(1), .ZERO_REG(1'b0)) u_zr0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .fwd_sel(fwd_sel[2]), .id_bypass(id_bypass[2]), .stall(stall[2]), .bubble(bubble[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=0x%h want=0x%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] obs(input int which, input int fld);
        logic [7:0] r;
        r = 8'h00;
        case (fld)
            F_FWD:   r = {4'b0, fwd_sel[which]};
            F_STL:   r = {7'b0, stall[which]};
            F_BUB:   r = {7'b0, bubble[which]};
            default: r = {6'b0, id_bypass[which]};
        endcase
        return r;
    endfunction

    task automatic expect_at(input int ofs, input int which, input int fld,
                             input logic [7:0] val, input string tag);
        q_cyc.push_back(cyc + ofs);
        q_which.push_back(which);
        q_fld.push_back(fld);
        q_val.push_back(val);
        q_tag.push_back(tag);
    endtask

    // Present one ID-stage instruction for the coming cycle
    task automatic tick(input int v, input int s0, input int s1, input int rd,
                        input int rw, input int mr, input int fl);
        @(posedge clk);
        #1;
        id_valid    = (v != 0);
        id_src      = {AW'(s1), AW'(s0)};
        id_rd       = AW'(rd);
        id_regwrite = (rw != 0);
        id_memread  = (mr != 0);
        flush       = (fl != 0);
    endtask

    task automatic nop();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard drain: compare every expectation due this cycle
    always @(negedge clk) begin : sb_mon
        int i;
        i = 0;
        while (i < q_cyc.size()) begin
            if (q_cyc[i] == cyc) begin
                check(q_tag[i], obs(q_which[i], q_fld[i]), q_val[i]);
                q_cyc.delete(i);
                q_which.delete(i);
                q_fld.delete(i);
                q_val.delete(i);
                q_tag.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b1;
        id_valid    = 1'b0;
        id_src      = '0;
        id_rd       = '0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        #2;
        // Reset state; bubble follows flush even in reset
        for (int w = 0; w < 3; w++) begin
            check("rst_fwd",    obs(w, F_FWD), 8'h00);
            check("rst_byp",    obs(w, F_BYP), 8'h00);
            check("rst_stall",  obs(w, F_STL), 8'h00);
            check("rst_bubble", obs(w, F_BUB), 8'h01);
        end
        flush = 1'b0;
        #1;
        check("rst_bubble_lo", obs(W_A, F_BUB), 8'h00);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // EX/MEM forwarding on both operands
        tick(1, 1, 2, 3, 1, 0, 0);
        tick(1, 3, 3, 4, 1, 0, 0);
        expect_at(0, W_A, F_STL, 8'h00, "t1_nostall");
        expect_at(1, W_A, F_FWD, 8'h05, "t1_exmem");
        nop();
        // Two producers of r3 in flight: EX/MEM must win
        tick(1, 1, 2, 3, 1, 0, 0);
        tick(1, 1, 2, 3, 1, 0, 0);
        tick(1, 3, 3, 4, 1, 0, 0);
        expect_at(1, W_A, F_FWD, 8'h05, "t1_prio");
        nop();
        nop();

        // MEM/WB forwarding and write-through bypass
        tick(1, 1, 2, 7, 1, 0, 0);
        nop();
        tick(1, 7, 9, 10, 1, 0, 0);
        expect_at(1, W_A, F_FWD, 8'h02, "t2_memwb");
        tick(1, 9, 7, 11, 1, 0, 0);
        expect_at(0, W_A, F_BYP, 8'h02, "t2_bypass");
        nop();
        nop();

        // Writes to r0: masked with ZERO_REG=1, forwarded with ZERO_REG=0
        tick(1, 1, 2, 0, 1, 0, 0);
        nop();
        tick(1, 0, 9, 12, 1, 0, 0);
        expect_at(1, W_A,  F_FWD, 8'h00, "t3_zr1_fwd");
        expect_at(1, W_Z0, F_FWD, 8'h02, "t3_zr0_fwd");
        tick(1, 0, 9, 13, 1, 0, 0);
        expect_at(0, W_A,  F_BYP, 8'h00, "t3_zr1_byp");
        expect_at(0, W_Z0, F_BYP, 8'h01, "t3_zr0_byp");
        nop();
        nop();

        // Load-use with LOAD_LAT=1: one stall cycle, then MEM/WB forward
        tick(1, 1, 2, 5, 1, 1, 0);
        tick(1, 8, 5, 14, 1, 0, 0);
        expect_at(0, W_A, F_STL, 8'h01, "t4_stall");
        expect_at(0, W_A, F_BUB, 8'h01, "t4_bubble");
        tick(1, 8, 5, 14, 1, 0, 0);
        expect_at(0, W_A, F_STL, 8'h00, "t4_release");
        expect_at(0, W_A, F_BUB, 8'h00, "t4_bubble_off");
        expect_at(1, W_A, F_FWD, 8'h08, "t4_fwd_memwb");
        repeat (4) nop();

        // Load-use with LOAD_LAT=3: three stall cycles
        tick(1, 1, 2, 5, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 8, 5, 14, 1, 0, 0);
            expect_at(0, W_L3, F_STL, 8'h01, $sformatf("t5_stall%0d", i));
            expect_at(0, W_L3, F_BUB, 8'h01, $sformatf("t5_bubble%0d", i));
            if (i == 2) expect_at(0, W_L3, F_BYP, 8'h02, "t5_bypass");
        end
        tick(1, 8, 5, 14, 1, 0, 0);
        expect_at(0, W_L3, F_STL, 8'h00, "t5_release");
        expect_at(0, W_L3, F_BUB, 8'h00, "t5_bubble_off");
        expect_at(1, W_L3, F_FWD, 8'h00, "t5_no_fwd");
        repeat (4) nop();

        // Flush in the second stall cycle cancels the remaining stall
        tick(1, 1, 2, 5, 1, 1, 0);
        tick(1, 8, 5, 14, 1, 0, 0);
        expect_at(0, W_L3, F_STL, 8'h01, "t6_stall0");
        tick(1, 8, 5, 14, 1, 0, 1);
        expect_at(0, W_L3, F_STL, 8'h01, "t6_stall1");
        expect_at(0, W_L3, F_BUB, 8'h01, "t6_bubble1");
        nop();
        expect_at(0, W_L3, F_STL, 8'h00, "t6_stall_off");
        expect_at(0, W_L3, F_BUB, 8'h00, "t6_bubble_off");
        nop();
        expect_at(0, W_L3, F_STL, 8'h00, "t6_stays_off");
        repeat (2) nop();

        // Asynchronous reset in the middle of a LOAD_LAT=3 stall
        tick(1, 1, 2, 5, 1, 1, 0);
        tick(1, 8, 5, 14, 1, 0, 0);
        tick(1, 8, 5, 14, 1, 0, 0);
        tick(1, 8, 5, 14, 1, 0, 0);
        #2;
        check("t7_pre_stall", obs(W_L3, F_STL), 8'h01);
        check("t7_pre_fwd",   obs(W_A,  F_FWD), 8'h08);
        rst_n = 1'b0;
        #1;
        check("t7_rst_stall",  obs(W_L3, F_STL), 8'h00);
        check("t7_rst_fwd_l3", obs(W_L3, F_FWD), 8'h00);
        check("t7_rst_fwd_a",  obs(W_A,  F_FWD), 8'h00);
        rst_n = 1'b1;
        nop();
        nop();
        tick(1, 1, 2, 3, 1, 0, 0);
        tick(1, 3, 6, 4, 1, 0, 0);
        expect_at(1, W_A,  F_FWD, 8'h01, "t7_after_a");
        expect_at(1, W_L3, F_FWD, 8'h01, "t7_after_l3");
        nop();
        nop();

        repeat (3) @(posedge clk);
        check("sb_empty", 8'(q_cyc.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
